// File: rtl/psc_3ph_gate_sequencer.sv
// Three-phase gate sequencer: bootstrap precharge, per-phase dead-time and fault trip latch.
// Latency: every output is registered and shows the decision made at the previous ACLK edge.
// Backpressure: none. Fault and en=0 force all gates off on the next cycle.
// Optional feature macro: GATE_SEQ_MIN_PULSE_EN enables the minimum gate on-time (MIN_PULSE).
module psc_3ph_gate_sequencer #(
   parameter int DT_W        = 8,
   parameter int BOOT_CYCLES = 1000,
   parameter int MIN_PULSE   = 4
) (
   input  logic            ACLK,
   input  logic            ARESET,
   input  logic            en,
   input  logic [DT_W-1:0] dt_cycles,
   input  logic            trip_clr,
   input  logic            fault_in,
   input  logic [2:0]      pwm_in,
   output logic [2:0]      gate_hi,
   output logic [2:0]      gate_lo,
   output logic [1:0]      state,
   output logic            trip_latched
);

   typedef enum logic [1:0] {
      S_OFF  = 2'd0,
      S_BOOT = 2'd1,
      S_RUN  = 2'd2,
      S_TRIP = 2'd3
   } state_t;

`ifdef GATE_SEQ_MIN_PULSE_EN
   localparam bit MP_EN = 1'b1;
`else
   localparam bit MP_EN = 1'b0;
`endif

   // Boot counter counts 0..BOOT_CYCLES-1; hold counter counts MIN_PULSE-1..0.
   localparam int BOOT_W = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
   localparam int HOLD_W = (MIN_PULSE > 1) ? $clog2(MIN_PULSE) : 1;
   localparam logic [BOOT_W-1:0] BOOT_LAST = BOOT_W'(BOOT_CYCLES - 1);
   // Without the minimum-pulse feature the hold counter is never loaded and stays zero.
   localparam logic [HOLD_W-1:0] HOLD_LOAD = MP_EN ? HOLD_W'(MIN_PULSE - 1) : '0;

   state_t                   state_q, state_d;
   logic [BOOT_W-1:0]        boot_cnt_q, boot_cnt_d;
   logic [DT_W-1:0]          dt_lat_q, dt_lat_d;
   logic [2:0]               applied_q, applied_d;   // 1 = high side is (or becomes) the on side
   logic [2:0][DT_W-1:0]     dt_cnt_q, dt_cnt_d;     // remaining dead-time cycles per phase
   logic [2:0][HOLD_W-1:0]   hold_q, hold_d;         // remaining forced on-time per phase
   logic [2:0]               gate_hi_q, gate_hi_d;
   logic [2:0]               gate_lo_q, gate_lo_d;
   logic                     trip_q, trip_d;

   // Next-state, per-phase dead-time engine and next gate values.
   always_comb begin
      state_d    = state_q;
      boot_cnt_d = boot_cnt_q;
      dt_lat_d   = dt_lat_q;
      applied_d  = applied_q;
      dt_cnt_d   = dt_cnt_q;
      hold_d     = hold_q;
      gate_hi_d  = 3'b000;
      gate_lo_d  = 3'b000;

      if (fault_in) begin
         // Fault overrides everything: trip with all gates off next cycle.
         state_d    = S_TRIP;
         boot_cnt_d = '0;
         applied_d  = 3'b000;
         dt_cnt_d   = '0;
         hold_d     = '0;
      end else begin
         case (state_q)
            S_OFF: begin
               boot_cnt_d = '0;
               applied_d  = 3'b000;
               dt_cnt_d   = '0;
               hold_d     = '0;
               if (en) begin
                  state_d   = S_BOOT;
                  // Zero dead-time is not allowed; one cycle is the floor.
                  dt_lat_d  = (dt_cycles == '0) ? DT_W'(1) : dt_cycles;
                  gate_lo_d = 3'b111;
               end
            end

            S_BOOT: begin
               if (!en) begin
                  state_d    = S_OFF;
                  boot_cnt_d = '0;
               end else if (boot_cnt_q == BOOT_LAST) begin
                  // Low sides stay on into RUN: the engine starts with every phase on LO.
                  state_d    = S_RUN;
                  boot_cnt_d = '0;
                  applied_d  = 3'b000;
                  dt_cnt_d   = '0;
                  hold_d     = '0;
                  gate_lo_d  = 3'b111;
               end else begin
                  boot_cnt_d = boot_cnt_q + 1'b1;
                  gate_lo_d  = 3'b111;
               end
            end

            S_RUN: begin
               if (!en) begin
                  state_d   = S_OFF;
                  applied_d = 3'b000;
                  dt_cnt_d  = '0;
                  hold_d    = '0;
               end else begin
                  for (int k = 0; k < 3; k++) begin
                     if (dt_cnt_q[k] != '0) begin
                        if (pwm_in[k] != applied_q[k]) begin
                           // Reverted request: restart a full dead-time toward the new side.
                           applied_d[k] = pwm_in[k];
                           dt_cnt_d[k]  = dt_lat_q;
                        end else begin
                           dt_cnt_d[k] = dt_cnt_q[k] - 1'b1;
                           if (dt_cnt_q[k] == DT_W'(1)) begin
                              hold_d[k] = HOLD_LOAD;
                           end
                        end
                     end else if (hold_q[k] != '0) begin
                        // Side is inside its minimum on-time; any request waits.
                        hold_d[k] = hold_q[k] - 1'b1;
                     end else if (pwm_in[k] != applied_q[k]) begin
                        applied_d[k] = pwm_in[k];
                        dt_cnt_d[k]  = dt_lat_q;
                     end
                     gate_hi_d[k] = (dt_cnt_d[k] == '0) &&  applied_d[k];
                     gate_lo_d[k] = (dt_cnt_d[k] == '0) && !applied_d[k];
                  end
               end
            end

            S_TRIP: begin
               // fault_in is already known low here.
               if (trip_clr && !en) begin
                  state_d = S_OFF;
               end
            end

            default: begin
               state_d = S_TRIP;
            end
         endcase
      end

      trip_d = (state_d == S_TRIP);
   end

   // State, counters and registered gate outputs.
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         state_q    <= S_OFF;
         boot_cnt_q <= '0;
         dt_lat_q   <= '0;
         applied_q  <= 3'b000;
         dt_cnt_q   <= '0;
         hold_q     <= '0;
         gate_hi_q  <= 3'b000;
         gate_lo_q  <= 3'b000;
         trip_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         boot_cnt_q <= boot_cnt_d;
         dt_lat_q   <= dt_lat_d;
         applied_q  <= applied_d;
         dt_cnt_q   <= dt_cnt_d;
         hold_q     <= hold_d;
         gate_hi_q  <= gate_hi_d;
         gate_lo_q  <= gate_lo_d;
         trip_q     <= trip_d;
      end
   end

   assign gate_hi      = gate_hi_q;
   assign gate_lo      = gate_lo_q;
   assign state        = state_q;
   assign trip_latched = trip_q;

endmodule

// File: tb/tb_psc_3ph_gate_sequencer.sv
// Directed bench for psc_3ph_gate_sequencer (default build, dead-time only).
// Inputs change 1 ns after a rising edge; outputs are read at that same point.
// A negedge monitor checks that no phase ever drives both gates.
module tb_psc_3ph_gate_sequencer;

   logic       ACLK;
   logic       ARESET;
   logic       en;
   logic [7:0] dt_cycles;
   logic       trip_clr;
   logic       fault_in;
   logic [2:0] pwm_in;
   logic [2:0] gate_hi;
   logic [2:0] gate_lo;
   logic [1:0] state;
   logic       trip_latched;

   int errors = 0;
   int checks = 0;

   psc_3ph_gate_sequencer #(
      .DT_W        (8),
      .BOOT_CYCLES (1000),
      .MIN_PULSE   (4)
   ) dut (
      .ACLK         (ACLK),
      .ARESET       (ARESET),
      .en           (en),
      .dt_cycles    (dt_cycles),
      .trip_clr     (trip_clr),
      .fault_in     (fault_in),
      .pwm_in       (pwm_in),
      .gate_hi      (gate_hi),
      .gate_lo      (gate_lo),
      .state        (state),
      .trip_latched (trip_latched)
   );

   initial begin
      ACLK = 1'b0;
      forever #5 ACLK = ~ACLK;
   end

   // Shoot-through monitor.
   always @(negedge ACLK) begin
      if (!ARESET) begin
         checks++;
         if ((gate_hi & gate_lo) !== 3'b000) begin
            errors++;
            $display("FAIL shoot_through t=%0t hi=%b lo=%b required hi&lo=000", $time, gate_hi, gate_lo);
         end
      end
   end

   task automatic step();
      @(posedge ACLK);
      #1;
   endtask

   task automatic test_reset();
      ARESET = 1'b0; en = 1'b0; dt_cycles = 8'd5; trip_clr = 1'b0; fault_in = 1'b0; pwm_in = 3'b000;
      #2 ARESET = 1'b1;
      en = 1'b1;  // must be ignored while reset is held
      repeat (3) @(posedge ACLK);
      #1;
      checks++; if (gate_hi !== 3'b000) begin errors++; $display("FAIL reset_hi got=%b exp=000", gate_hi); end
      checks++; if (gate_lo !== 3'b000) begin errors++; $display("FAIL reset_lo got=%b exp=000", gate_lo); end
      checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", state); end
      checks++; if (trip_latched !== 1'b0) begin errors++; $display("FAIL reset_trip got=%b exp=0", trip_latched); end
      ARESET = 1'b0;
   endtask

   task automatic test_bootstrap();
      int bad;
      bad = 0;
      step();
      checks++; if (state !== 2'd1 || gate_lo !== 3'b111 || gate_hi !== 3'b000) begin
         errors++; $display("FAIL boot_entry state=%0d hi=%b lo=%b exp state=1 hi=000 lo=111", state, gate_hi, gate_lo);
      end
      for (int i = 2; i <= 1000; i++) begin
         step();
         if (state !== 2'd1 || gate_lo !== 3'b111 || gate_hi !== 3'b000) bad++;
      end
      checks++; if (bad !== 0) begin errors++; $display("FAIL boot_hold bad_cycles=%0d exp=0", bad); end
      step();
      checks++; if (state !== 2'd2 || gate_lo !== 3'b111 || gate_hi !== 3'b000) begin
         errors++; $display("FAIL boot_to_run state=%0d hi=%b lo=%b exp state=2 hi=000 lo=111", state, gate_hi, gate_lo);
      end
   endtask

   task automatic test_dead_time();
      int bad;
      bad = 0;
      dt_cycles = 8'd2;  // changed while running: must not affect the latched 5
      pwm_in = 3'b001;
      step();
      checks++; if (gate_hi !== 3'b000 || gate_lo !== 3'b110) begin
         errors++; $display("FAIL dt_first_off hi=%b lo=%b exp hi=000 lo=110", gate_hi, gate_lo);
      end
      for (int i = 2; i <= 5; i++) begin
         step();
         if (gate_hi[0] !== 1'b0 || gate_lo[0] !== 1'b0) bad++;
      end
      checks++; if (bad !== 0) begin errors++; $display("FAIL dt_off_window bad_cycles=%0d exp=0", bad); end
      step();
      checks++; if (gate_hi !== 3'b001 || gate_lo !== 3'b110) begin
         errors++; $display("FAIL dt_hi_on hi=%b lo=%b exp hi=001 lo=110", gate_hi, gate_lo);
      end
   endtask

   task automatic test_revert();
      int bad;
      bad = 0;
      pwm_in = 3'b011;
      step();
      if (gate_hi[1] !== 1'b0 || gate_lo[1] !== 1'b0) bad++;
      step();
      if (gate_hi[1] !== 1'b0 || gate_lo[1] !== 1'b0) bad++;
      pwm_in = 3'b001;
      for (int i = 1; i <= 5; i++) begin
         step();
         if (gate_hi[1] !== 1'b0 || gate_lo[1] !== 1'b0) bad++;
      end
      checks++; if (bad !== 0) begin errors++; $display("FAIL revert_off_window bad_cycles=%0d exp=0", bad); end
      step();
      checks++; if (gate_hi !== 3'b001 || gate_lo !== 3'b110) begin
         errors++; $display("FAIL revert_lo_back hi=%b lo=%b exp hi=001 lo=110", gate_hi, gate_lo);
      end
   endtask

   task automatic test_simultaneous();
      int bad;
      bad = 0;
      pwm_in = 3'b110;
      step();
      checks++; if (gate_hi !== 3'b000 || gate_lo !== 3'b000) begin
         errors++; $display("FAIL simul_all_off hi=%b lo=%b exp hi=000 lo=000", gate_hi, gate_lo);
      end
      for (int i = 2; i <= 5; i++) begin
         step();
         if (gate_hi !== 3'b000 || gate_lo !== 3'b000) bad++;
      end
      checks++; if (bad !== 0) begin errors++; $display("FAIL simul_off_window bad_cycles=%0d exp=0", bad); end
      step();
      checks++; if (gate_hi !== 3'b110 || gate_lo !== 3'b001) begin
         errors++; $display("FAIL simul_swap hi=%b lo=%b exp hi=110 lo=001", gate_hi, gate_lo);
      end
   endtask

   task automatic test_trip();
      fault_in = 1'b1;
      step();
      checks++; if (gate_hi !== 3'b000 || gate_lo !== 3'b000 || state !== 2'd3 || trip_latched !== 1'b1) begin
         errors++; $display("FAIL trip_entry state=%0d trip=%b hi=%b lo=%b exp state=3 trip=1 hi=000 lo=000",
                            state, trip_latched, gate_hi, gate_lo);
      end
      fault_in = 1'b0; en = 1'b1; trip_clr = 1'b1;
      step();
      checks++; if (state !== 2'd3) begin errors++; $display("FAIL trip_clr_en_high state=%0d exp=3", state); end
      trip_clr = 1'b0; en = 1'b0;
      step();
      checks++; if (state !== 2'd3) begin errors++; $display("FAIL trip_hold_no_clr state=%0d exp=3", state); end
      trip_clr = 1'b1; fault_in = 1'b1;
      step();
      checks++; if (state !== 2'd3) begin errors++; $display("FAIL trip_clr_fault_high state=%0d exp=3", state); end
      fault_in = 1'b0;
      step();
      checks++; if (state !== 2'd0 || trip_latched !== 1'b0 || gate_hi !== 3'b000 || gate_lo !== 3'b000) begin
         errors++; $display("FAIL trip_release state=%0d trip=%b hi=%b lo=%b exp state=0 trip=0 hi=000 lo=000",
                            state, trip_latched, gate_hi, gate_lo);
      end
      trip_clr = 1'b0;
   endtask

   task automatic test_boot_abort();
      pwm_in = 3'b000; en = 1'b1;
      step();
      checks++; if (state !== 2'd1) begin errors++; $display("FAIL abort_boot_entry state=%0d exp=1", state); end
      repeat (5) step();
      en = 1'b0;
      step();
      checks++; if (state !== 2'd0 || gate_lo !== 3'b000 || gate_hi !== 3'b000) begin
         errors++; $display("FAIL abort_to_off state=%0d hi=%b lo=%b exp state=0 hi=000 lo=000", state, gate_hi, gate_lo);
      end
   endtask

   task automatic test_min_dead_time();
      dt_cycles = 8'd0; pwm_in = 3'b000; en = 1'b1;
      repeat (1001) step();
      checks++; if (state !== 2'd2) begin errors++; $display("FAIL dt0_run state=%0d exp=2", state); end
      pwm_in = 3'b100;
      step();
      checks++; if (gate_hi !== 3'b000 || gate_lo !== 3'b011) begin
         errors++; $display("FAIL dt0_off hi=%b lo=%b exp hi=000 lo=011", gate_hi, gate_lo);
      end
      step();
      checks++; if (gate_hi !== 3'b100 || gate_lo !== 3'b011) begin
         errors++; $display("FAIL dt0_hi_on hi=%b lo=%b exp hi=100 lo=011", gate_hi, gate_lo);
      end
      pwm_in = 3'b000;
      step();
      checks++; if (gate_hi !== 3'b000 || gate_lo !== 3'b011) begin
         errors++; $display("FAIL dt0_back_off hi=%b lo=%b exp hi=000 lo=011", gate_hi, gate_lo);
      end
      step();
      checks++; if (gate_hi !== 3'b000 || gate_lo !== 3'b111) begin
         errors++; $display("FAIL dt0_lo_on hi=%b lo=%b exp hi=000 lo=111", gate_hi, gate_lo);
      end
   endtask

   task automatic test_random_pwm();
      for (int i = 0; i < 20000; i++) begin
         pwm_in = 3'($urandom_range(0, 7));
         step();
      end
      checks++; if (state !== 2'd2) begin errors++; $display("FAIL random_still_run state=%0d exp=2", state); end
      en = 1'b0;
      step();
      checks++; if (state !== 2'd0 || gate_hi !== 3'b000 || gate_lo !== 3'b000) begin
         errors++; $display("FAIL run_to_off state=%0d hi=%b lo=%b exp state=0 hi=000 lo=000", state, gate_hi, gate_lo);
      end
   endtask

   initial begin
      test_reset();
      test_bootstrap();
      test_dead_time();
      test_revert();
      test_simultaneous();
      test_trip();
      test_boot_abort();
      test_min_dead_time();
      test_random_pwm();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
